// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional registered
// write-first read, optional hardwired-zero entry 0 and a sequenced bulk clear.
module regfile_mp #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int NRD      = 2,
   parameter int READ_LAT = 0,
   parameter int ZERO_REG = 0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 we0,
   input  logic [AW-1:0]        waddr0,
   input  logic [WIDTH-1:0]     wdata0,
   input  logic                 we1,
   input  logic [AW-1:0]        waddr1,
   input  logic [WIDTH-1:0]     wdata1,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*WIDTH-1:0] rdata,
   input  logic                 clr_req,
   output logic                 clr_busy,
   output logic                 wr_drop
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t                         state, state_nxt;
   logic [AW-1:0]                  ptr, ptr_nxt;
   logic                           clr_wr;
   logic [DEPTH-1:0][WIDTH-1:0]    mem, mem_nxt;
   logic                           req0, req1;
   logic                           wen0, wen1;
   logic                           drop_nxt;

   // Writes aimed at a hardwired zero entry are not real writes: never stored, never dropped.
   assign req0 = we0 & ~((ZERO_REG != 0) && (waddr0 == '0));
   assign req1 = we1 & ~((ZERO_REG != 0) && (waddr1 == '0));

   assign wen0     = req0 & (state == IDLE);
   assign wen1     = req1 & (state == IDLE);
   assign drop_nxt = (state == CLEAR) & (req0 | req1);
   assign clr_busy = (state == CLEAR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         ptr     <= '0;
         wr_drop <= 1'b0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         wr_drop <= drop_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      clr_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               ptr_nxt   = '0;
            end
         end
         CLEAR: begin
            clr_wr  = 1'b1;
            ptr_nxt = ptr + AW'(1);
            if (ptr == LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next storage image; user writes and clear writes never overlap (IDLE vs CLEAR).
   always_comb begin
      mem_nxt = mem;
      if (wen0) mem_nxt[waddr0] = wdata0;
      if (wen1) mem_nxt[waddr1] = wdata1;
      if (clr_wr) mem_nxt[ptr] = '0;
      if (ZERO_REG != 0) mem_nxt[0] = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mem <= '0;
      else          mem <= mem_nxt;
   end

   // Registered reads sample the post-edge image, giving write-first behaviour for free.
   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0] a;
         assign a = raddr[gi*AW +: AW];
         if (READ_LAT == 0) begin : g_comb
            assign rdata[gi*WIDTH +: WIDTH] = mem[a];
         end else begin : g_reg
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) q <= '0;
               else          q <= mem_nxt[a];
            end
            assign rdata[gi*WIDTH +: WIDTH] = q;
         end
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three parameterisations share one stimulus
// stream and are checked every cycle against one behavioural model.
module tb_regfile_mp;

   logic        clk;
   logic        reset_n;
   logic        we0, we1, clr_req;
   logic [2:0]  waddr0, waddr1;
   logic [15:0] wdata0, wdata1;
   logic [5:0]  raddr;
   logic [31:0] rd_a, rd_b, rd_z;
   logic        busy_a, busy_b, busy_z;
   logic        drop_a, drop_b, drop_z;

   int vecs = 0;
   int errs = 0;

   // Model state
   logic [15:0] m [8];
   logic [15:0] r1 [2];
   bit          mbusy, mdrop, mdropz;
   int          mptr;

   regfile_mp #(.WIDTH(16), .DEPTH(8), .NRD(2), .READ_LAT(0), .ZERO_REG(0)) u_lat0 (
      .clk(clk), .reset_n(reset_n),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr(raddr), .rdata(rd_a),
      .clr_req(clr_req), .clr_busy(busy_a), .wr_drop(drop_a));

   regfile_mp #(.WIDTH(16), .DEPTH(8), .NRD(2), .READ_LAT(1), .ZERO_REG(0)) u_lat1 (
      .clk(clk), .reset_n(reset_n),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr(raddr), .rdata(rd_b),
      .clr_req(clr_req), .clr_busy(busy_b), .wr_drop(drop_b));

   regfile_mp #(.WIDTH(16), .DEPTH(8), .NRD(2), .READ_LAT(0), .ZERO_REG(1)) u_zero (
      .clk(clk), .reset_n(reset_n),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr(raddr), .rdata(rd_z),
      .clr_req(clr_req), .clr_busy(busy_z), .wr_drop(drop_z));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2:0] ra(input int i);
      return raddr[i*3 +: 3];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: storage array, busy flag, clear pointer.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) m[i] = '0;
         r1[0] = '0; r1[1] = '0;
         mbusy = 0; mdrop = 0; mdropz = 0; mptr = 0;
      end else begin
         if (!mbusy) begin
            if (we0) m[waddr0] = wdata0;
            if (we1) m[waddr1] = wdata1;
            mdrop = 0; mdropz = 0;
            if (clr_req) begin
               mbusy = 1;
               mptr  = 0;
            end
         end else begin
            mdrop  = we0 || we1;
            mdropz = (we0 && waddr0 != 0) || (we1 && waddr1 != 0);
            m[mptr] = '0;
            mptr++;
            if (mptr == 8) mbusy = 0;
         end
         for (int i = 0; i < 2; i++) r1[i] = m[ra(i)];
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk("lat0_rd", 32'(rd_a[i*16 +: 16]), 32'(m[ra(i)]));
         chk("lat1_rd", 32'(rd_b[i*16 +: 16]), 32'(r1[i]));
         chk("zero_rd", 32'(rd_z[i*16 +: 16]), (ra(i) == 3'd0) ? 32'h0 : 32'(m[ra(i)]));
      end
      chk("busy_a", 32'(busy_a), 32'(mbusy));
      chk("busy_b", 32'(busy_b), 32'(mbusy));
      chk("busy_z", 32'(busy_z), 32'(mbusy));
      chk("drop_a", 32'(drop_a), 32'(mdrop));
      chk("drop_b", 32'(drop_b), 32'(mdrop));
      chk("drop_z", 32'(drop_z), 32'(mdropz));
   end

   initial begin
      int n;
      int drops;
      reset_n = 1'b1;
      we0 = 0; we1 = 0; clr_req = 0;
      waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; raddr = 0;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state: every address on both ports reads zero
      for (int a = 0; a < 8; a++) begin
         raddr = {3'(7 - a), 3'(a)};
         tick();
         chk("rst_lat0", rd_a, 32'h0);
         chk("rst_lat1", rd_b, 32'h0);
      end
      chk("rst_busy", 32'(busy_a), 32'h0);

      // Single write, both ports read it back
      we0 = 1; waddr0 = 3; wdata0 = 16'hA5A5; raddr = {3'd3, 3'd3};
      tick();
      we0 = 0;
      chk("wr3_lat0", rd_a, 32'hA5A5A5A5);
      tick();
      chk("wr3_lat1", rd_b, 32'hA5A5A5A5);

      // Same-address collision: port 1 wins
      we0 = 1; waddr0 = 5; wdata0 = 16'h1111;
      we1 = 1; waddr1 = 5; wdata1 = 16'h2222; raddr = {3'd5, 3'd5};
      tick();
      we0 = 0; we1 = 0;
      chk("wpri_lat0", rd_a, 32'h22222222);
      chk("wpri_lat1", rd_b, 32'h22222222);

      // Write-first bypass on the registered read
      we0 = 1; waddr0 = 2; wdata0 = 16'hBEEF; raddr = {3'd5, 3'd2};
      tick();
      we0 = 0;
      chk("byp_lat1", 32'(rd_b[15:0]), 32'h0000BEEF);

      // Fill all entries
      for (int a = 0; a < 8; a++) begin
         we0 = 1; waddr0 = 3'(a); wdata0 = 16'h1000 + 16'(a) * 16'h0101;
         raddr = {3'(a), 3'(a)};
         tick();
      end
      we0 = 0;
      raddr = {3'd0, 3'd7};
      tick();
      chk("fill_lat0", rd_a, 32'h10001707);
      chk("fill_zero", rd_z, 32'h00001707);

      // Bulk clear; a write in the accepting cycle still commits, then gets cleared
      clr_req = 1; we1 = 1; waddr1 = 6; wdata1 = 16'h7777; raddr = {3'd1, 3'd6};
      tick();
      clr_req = 0; we1 = 0;
      chk("clr_busy1", 32'(busy_a), 32'h1);
      n = 0; drops = 0;
      while (busy_a && n < 20) begin
         n++;
         if (n == 3) begin we0 = 1; waddr0 = 1; wdata0 = 16'hDEAD; end
         if (n == 5) clr_req = 1;
         tick();
         we0 = 0; clr_req = 0;
         if (drop_a) drops++;
      end
      chk("clr_len", 32'(n), 32'd8);
      chk("clr_drop", 32'(drops), 32'd1);
      tick();
      chk("clr_norestart", 32'(busy_a), 32'h0);
      raddr = {3'd6, 3'd1};
      tick();
      chk("clr_rd", rd_a, 32'h0);

      // Mid-clear asynchronous reset
      for (int a = 4; a < 8; a++) begin
         we0 = 1; waddr0 = 3'(a); wdata0 = 16'hC000 + 16'(a);
         tick();
      end
      we0 = 0;
      raddr = {3'd7, 3'd4};
      clr_req = 1;
      tick();
      clr_req = 0;
      repeat (3) tick();
      chk("mid_busy_pre", 32'(busy_a), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_busy_a", 32'(busy_a), 32'h0);
      chk("mid_busy_b", 32'(busy_b), 32'h0);
      chk("mid_rd_a", rd_a, 32'h0);
      chk("mid_rd_b", rd_b, 32'h0);
      tick();
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         raddr = {3'(a + 4), 3'(a)};
         tick();
         chk("mid_sweep", rd_a, 32'h0);
      end

      // Hardwired zero entry
      we0 = 1; waddr0 = 0; wdata0 = 16'hFFFF; raddr = {3'd0, 3'd0};
      tick();
      we0 = 0;
      chk("zero_rd0", rd_z, 32'h0);
      chk("zero_plain", rd_a, 32'hFFFFFFFF);
      chk("zero_drop", 32'(drop_z), 32'h0);
      tick();
      chk("zero_drop2", 32'(drop_z), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
